// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM state codes and abort-source codes.
package mem_arbiter_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  // Saturating increment used by the data-streak counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic [7:0] max);
    return (val >= max) ? max : val + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Watchdog counter for the memory arbiter: clears on grant, counts while busy,
// flags terminal count at TIMEOUT-1.
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != TC_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one handshaked memory port between instruction fetch and data access,
// with data priority, a fetch-fairness streak limit and a watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  output logic          err_src
);

  localparam int DSW = $clog2(MAX_DSTREAK + 1);
  localparam logic [7:0] DS_MAX8 = 8'(MAX_DSTREAK);

  logic [1:0]    state_q, state_d;
  logic [DSW-1:0] dstreak_q, dstreak_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          err_q, err_d;
  logic          err_src_q, err_src_d;

  logic i_elig, d_elig, grant_d, grant_i;
  logic timer_clear, timer_en, timer_tc;

  // A requester is masked during its own ready cycle, since its req is still stale there.
  assign i_elig  = i_req && !i_ready_q;
  assign d_elig  = d_req && !d_ready_q;
  assign grant_d = d_elig && !(i_elig && (dstreak_q == DSW'(MAX_DSTREAK)));
  assign grant_i = i_elig && !grant_d;

  always_comb begin
    state_d     = state_q;
    dstreak_d   = dstreak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_src_d   = err_src_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d     = S_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          timer_clear = 1'b1;
          dstreak_d   = i_elig ? DSW'(sat_inc8(8'(dstreak_q), DS_MAX8)) : '0;
        end else if (grant_i) begin
          state_d     = S_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          timer_clear = 1'b1;
          dstreak_d   = '0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        timer_en = 1'b1;
        // Ack takes precedence over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (state_q == S_BUSY_D) begin
            d_ready_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (timer_tc) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == S_BUSY_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
            err_src_d = SRC_D;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = '0;
            err_src_d = SRC_I;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dstreak_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dstreak_q   <= dstreak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;
  assign err_src   = err_src_q;

endmodule
